// File: rtl/dcache_exception_stage_pkg.sv
// Shared constants for the D-cache exception stage.
// Exception codes and access-size byte masks.
package dcache_exception_stage_pkg;

    localparam int EXP_W = 7;

    localparam logic [EXP_W-1:0] EXP_ADEM = 7'h08;
    localparam logic [EXP_W-1:0] EXP_ALE  = 7'h09;

    localparam logic [7:0] MASK_BYTE  = 8'h01;
    localparam logic [7:0] MASK_HALF  = 8'h03;
    localparam logic [7:0] MASK_WORD  = 8'h0F;
    localparam logic [7:0] MASK_DWORD = 8'hFF;

endpackage

// File: rtl/dcache_exception_stage_align.sv
// Combinational privilege, mask-legality and alignment check.
// Priority: privilege, illegal mask, misalignment.
module cache_align_check
    import dcache_exception_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_BYTES = 4,
    parameter int EXP_WIDTH  = 7,
    parameter logic [EXP_WIDTH-1:0] MISALIGN_CODE =
        EXP_WIDTH'(EXP_ADEM),
    parameter bit PLV_CHECK  = 1'b1
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_BYTES-1:0] type_,
    input  logic [1:0]            plv,
    output logic [EXP_WIDTH-1:0]  exception
);

    localparam logic [EXP_WIDTH-1:0] ADEM =
        EXP_WIDTH'(EXP_ADEM);

    logic [7:0] m;
    logic       priv;
    logic       unused_addr;

    assign m    = 8'(type_);
    assign priv = PLV_CHECK && (plv == 2'd3) &&
                  addr[ADDR_WIDTH-1];
    assign unused_addr = ^addr[ADDR_WIDTH-2:3];

    always_comb begin
        exception = '0;
        if (priv) begin
            exception = ADEM;
        end else begin
            case (m)
                MASK_BYTE: exception = '0;
                MASK_HALF: begin
                    if (addr[0])
                        exception = MISALIGN_CODE;
                end
                MASK_WORD: begin
                    if (addr[1:0] != 2'b00)
                        exception = MISALIGN_CODE;
                end
                MASK_DWORD: begin
                    // A dword mask only exists on 8-byte datapaths
                    if (DATA_BYTES != 8)
                        exception = ADEM;
                    else if (addr[2:0] != 3'b000)
                        exception = MISALIGN_CODE;
                end
                default: exception = ADEM;
            endcase
        end
    end

endmodule

// File: rtl/dcache_exception_stage.sv
// Registered exception-check stage ahead of the D-cache request path.
// Valid/ready skid-free register, sticky first fault and fault counter.
module dcache_exception_stage
    import dcache_exception_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_BYTES = 4,
    parameter int EXP_WIDTH  = 7,
    parameter logic [EXP_WIDTH-1:0] MISALIGN_CODE =
        EXP_WIDTH'(EXP_ADEM),
    parameter bit PLV_CHECK  = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_BYTES-1:0] in_type,
    input  logic                  in_we,
    input  logic [1:0]            in_plv,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_BYTES-1:0] out_type,
    output logic                  out_we,
    output logic [EXP_WIDTH-1:0]  out_exception,
    output logic                  exp_pending,
    output logic [EXP_WIDTH-1:0]  exp_code,
    output logic [ADDR_WIDTH-1:0] exp_badv,
    input  logic                  exp_clear,
    output logic [CNT_WIDTH-1:0]  fault_cnt
);

    logic [EXP_WIDTH-1:0] chk_exc;
    logic                 accept;
    logic                 fault;

    cache_align_check #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_BYTES    (DATA_BYTES),
        .EXP_WIDTH     (EXP_WIDTH),
        .MISALIGN_CODE (MISALIGN_CODE),
        .PLV_CHECK     (PLV_CHECK)
    ) u_chk (
        .addr      (in_addr),
        .type_     (in_type),
        .plv       (in_plv),
        .exception (chk_exc)
    );

    assign in_ready = !out_valid || out_ready;
    // Flush wins over a same-cycle accept: no capture, no count
    assign accept   = in_valid && in_ready && !flush;
    assign fault    = accept && (chk_exc != '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid     <= 1'b0;
            out_addr      <= '0;
            out_type      <= '0;
            out_we        <= 1'b0;
            out_exception <= '0;
            exp_pending   <= 1'b0;
            exp_code      <= '0;
            exp_badv      <= '0;
            fault_cnt     <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid     <= 1'b1;
                out_addr      <= in_addr;
                out_type      <= in_type;
                out_we        <= in_we;
                out_exception <= chk_exc;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // A fault arriving with the ack replaces the old one
            if (fault && (!exp_pending || exp_clear)) begin
                exp_pending <= 1'b1;
                exp_code    <= chk_exc;
                exp_badv    <= in_addr;
            end else if (exp_clear) begin
                exp_pending <= 1'b0;
            end

            if (fault && (fault_cnt != '1))
                fault_cnt <= fault_cnt + 1'b1;
        end
    end

endmodule
